// File: rtl/round_pkg.sv
// Shared types and constants for the dice round controller.
// Used by round_ctrl (optional tie re-roll via ROUND_TIE_REROLL_EN).
package round_pkg;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_ROLL  = 3'd1,
    ST_DICE  = 3'd2,
    ST_SCORE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_WIN   = 3'd5
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int unsigned HOLD_CYCLES_DEF = 32'd3000000;
  localparam int unsigned WIN_CYCLES_DEF  = 32'd5000000;
  localparam int unsigned WIN_MARGIN_DEF  = 32'd2;

  localparam logic [3:0] SCORE_MAX = 4'd15;

  function automatic logic [3:0] abs_diff4(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic die_ok(input logic [3:0] d);
    return (d >= 4'd1) && (d <= 4'd6);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == SCORE_MAX) ? s : (s + 4'd1);
  endfunction

endpackage

// File: rtl/round_ctrl_edge_fall_det.sv
// Falling-edge detector for one button: one-cycle pulse when the level drops.
// History register updates every cycle, independent of controller state.
module edge_fall_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic fall_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_i;
    end
  end

  assign fall_o = prev_q & ~level_i;

endmodule

// File: rtl/round_ctrl.sv
// Two-player dice round controller: press gating, roll request, scoring, hold/win timing.
// Define ROUND_TIE_REROLL_EN to re-roll immediately on a tie instead of holding.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_WAIT  | collect one fresh press from each player
// ST_ROLL  | one-cycle roll request to both dice generators
// ST_DICE  | wait for dice_vld, latch dice, reject out-of-range values
// ST_SCORE | award the round to the larger die (saturating)
// ST_HOLD  | freeze display for HOLD_CYCLES, then check for game end
// ST_WIN   | show winner for WIN_CYCLES, pulse finish, then clear game
module round_ctrl
  import round_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned WIN_CYCLES  = WIN_CYCLES_DEF,
  parameter int unsigned WIN_MARGIN  = WIN_MARGIN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start1,
  input  logic       start2,
  output logic       roll,
  input  logic       dice_vld,
  input  logic [3:0] dice1,
  input  logic [3:0] dice2,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic       hold,
  output logic       finish
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] WIN_LAST  = 32'(WIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic        p1_q, p1_d, p2_q, p2_d;
  logic [3:0]  d1_q, d1_d, d2_q, d2_d;
  logic [3:0]  score1_q, score1_d, score2_q, score2_d;
  logic [1:0]  winner_q, winner_d;
  logic [31:0] cnt_q, cnt_d;
  logic        roll_q, roll_d, hold_q, hold_d, finish_q, finish_d;
  logic        fall1, fall2;

  edge_fall_det u_fall1 (.clk_i(clk), .rst_i(rst), .level_i(start1), .fall_o(fall1));
  edge_fall_det u_fall2 (.clk_i(clk), .rst_i(rst), .level_i(start2), .fall_o(fall2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_WAIT;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      d1_q     <= 4'd0;
      d2_q     <= 4'd0;
      score1_q <= 4'd0;
      score2_q <= 4'd0;
      winner_q <= WIN_NONE;
      cnt_q    <= 32'd0;
      roll_q   <= 1'b0;
      hold_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      roll_q   <= roll_d;
      hold_q   <= hold_d;
      finish_q <= finish_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_WAIT: begin
        if (p1_q && p2_q) begin
          state_d = ST_ROLL;
          p1_d    = 1'b0;
          p2_d    = 1'b0;
        end else begin
          p1_d = p1_q | fall1;
          p2_d = p2_q | fall2;
        end
      end
      ST_ROLL: state_d = ST_DICE;
      ST_DICE: begin
        if (dice_vld) begin
          d1_d    = dice1;
          d2_d    = dice2;
          state_d = (die_ok(dice1) && die_ok(dice2)) ? ST_SCORE : ST_WAIT;
        end
      end
      ST_SCORE: begin
        cnt_d   = 32'd0;
        state_d = ST_HOLD;
        if (d1_q > d2_q) begin
          score1_d = sat_inc(score1_q);
        end else if (d2_q > d1_q) begin
          score2_d = sat_inc(score2_q);
        end else begin
`ifdef ROUND_TIE_REROLL_EN
          state_d = ST_ROLL;
`else
          state_d = ST_HOLD;
`endif
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = 32'd0;
          if ({28'd0, abs_diff4(score1_q, score2_q)} >= WIN_MARGIN) begin
            state_d  = ST_WIN;
            winner_d = (score1_q > score2_q) ? WIN_P1 : WIN_P2;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_WIN: begin
        if (cnt_q == WIN_LAST) begin
          state_d  = ST_WAIT;
          cnt_d    = 32'd0;
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = WIN_NONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Outputs are registered from the next state so they align with it.
    roll_d   = (state_d == ST_ROLL);
    hold_d   = (state_d == ST_HOLD) || (state_d == ST_WIN);
    finish_d = (state_d == ST_WIN) && (cnt_d == WIN_LAST);
  end

  assign roll   = roll_q;
  assign hold   = hold_q;
  assign finish = finish_q;
  assign score1 = score1_q;
  assign score2 = score2_q;
  assign winner = winner_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: directed table, corner sequences, random rounds.
// Works with or without ROUND_TIE_REROLL_EN defined.
module tb_round_ctrl;

  localparam int HOLD   = 10;
  localparam int WINC   = 20;
  localparam int MARGIN = 2;

  logic       clk = 1'b0;
  logic       rst, start1, start2, dice_vld;
  logic [3:0] dice1, dice2;
  logic       roll, hold, finish;
  logic [3:0] score1, score2;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;
  int m1 = 0, m2 = 0;
  bit pend = 1'b0;

  typedef struct {
    logic [3:0] d1, d2, e1, e2;
    logic [1:0] ew;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  round_ctrl #(.HOLD_CYCLES(HOLD), .WIN_CYCLES(WINC), .WIN_MARGIN(MARGIN)) dut (
    .clk(clk), .rst(rst), .start1(start1), .start2(start2), .roll(roll),
    .dice_vld(dice_vld), .dice1(dice1), .dice2(dice2), .score1(score1),
    .score2(score2), .winner(winner), .hold(hold), .finish(finish)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Round outcome from the game rules, in plain integer arithmetic.
  task automatic model_round(input logic [3:0] d1, input logic [3:0] d2,
                             output logic [3:0] e1, output logic [3:0] e2,
                             output logic [1:0] ew);
    int a, b, diff;
    bit fault;
    a = m1; b = m2; ew = 2'b00;
    fault = (d1 == 0) || (d1 > 6) || (d2 == 0) || (d2 > 6);
    if (!fault) begin
      if (d1 > d2) a = (a >= 15) ? 15 : a + 1;
      else if (d2 > d1) b = (b >= 15) ? 15 : b + 1;
    end
    e1 = 4'(a); e2 = 4'(b);
    diff = (a > b) ? a - b : b - a;
    if (!fault && diff >= MARGIN) ew = (a > b) ? 2'b01 : 2'b10;
    m1 = (ew != 0) ? 0 : a;
    m2 = (ew != 0) ? 0 : b;
  endtask

  task automatic press_and_roll(input int gap, input bit p2first);
    if (gap == 0) begin
      start1 = 1'b0; start2 = 1'b0;
    end else begin
      if (p2first) start2 = 1'b0; else start1 = 1'b0;
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        check("roll_one_press", roll, 0);
      end
      if (p2first) start1 = 1'b0; else start2 = 1'b0;
    end
    @(negedge clk); check("roll_lat1", roll, 0);
    @(negedge clk); check("roll_lat2", roll, 1);
    start1 = 1'b1; start2 = 1'b1;
    @(negedge clk); check("roll_single", roll, 0);
  endtask

  task automatic start_round(input int gap, input bit p2first);
    if (pend) begin
      @(negedge clk); check("reroll_single", roll, 0);
    end else begin
      press_and_roll(gap, p2first);
    end
  endtask

  // Called in DICE at a falling clock edge; returns in WAIT (or, on re-roll, in ROLL).
  task automatic dice_phase(input logic [3:0] d1, input logic [3:0] d2,
                            input logic [3:0] o1, input logic [3:0] o2,
                            input logic [3:0] e1, input logic [3:0] e2,
                            input logic [1:0] ew, input int dly);
    bit fault, tie;
    int n;
    fault = (d1 == 0) || (d1 > 6) || (d2 == 0) || (d2 > 6);
    tie   = !fault && (d1 == d2);
    pend  = 1'b0;
    for (int i = 0; i < dly; i++) @(negedge clk);
    dice1 = d1; dice2 = d2; dice_vld = 1'b1;
    @(negedge clk);
    dice_vld = 1'b0;
    dice1 = 4'($urandom_range(0, 15)); dice2 = 4'($urandom_range(0, 15));
    check("score1_pre", score1, o1);
    check("score2_pre", score2, o2);
    check("hold_pre", hold, 0);
    if (fault) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("fault_hold", hold, 0);
        check("fault_roll", roll, 0);
      end
      check("fault_score1", score1, o1);
      check("fault_score2", score2, o2);
      return;
    end
    @(negedge clk);
    check("score1", score1, e1);
    check("score2", score2, e2);
`ifdef ROUND_TIE_REROLL_EN
    if (tie) begin
      check("reroll_roll", roll, 1);
      check("reroll_hold", hold, 0);
      pend = 1'b1;
      return;
    end
`endif
    n = 0;
    while (hold === 1'b1 && winner == 2'b00 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("hold_len", n, HOLD);
    check("winner", winner, ew);
    if (ew != 0) begin
      check("win_hold", hold, 1);
      n = 1;
      while (finish !== 1'b1 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("win_len", n, WINC);
      check("finish_hold", hold, 1);
      @(negedge clk);
      check("finish_single", finish, 0);
      check("clear_score1", score1, 0);
      check("clear_score2", score2, 0);
      check("clear_winner", winner, 0);
      check("clear_hold", hold, 0);
    end else begin
      check("post_hold", hold, 0);
    end
  endtask

  task automatic play_model(input logic [3:0] d1, input logic [3:0] d2,
                            input int gap, input bit p2first, input int dly);
    logic [3:0] o1, o2, e1, e2;
    logic [1:0] ew;
    o1 = 4'(m1); o2 = 4'(m2);
    model_round(d1, d2, e1, e2, ew);
    start_round(gap, p2first);
    dice_phase(d1, d2, o1, o2, e1, e2, ew, dly);
  endtask

  function automatic logic [3:0] rand_die();
    int pick;
    if ($urandom_range(0, 9) < 8) return 4'($urandom_range(1, 6));
    pick = int'($urandom_range(0, 9));
    return (pick == 0) ? 4'd0 : 4'(pick + 6);
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] o1, o2, e1, e2;
    logic [1:0] ew;
    int n;

    tbl[0]  = '{4'd5, 4'd3, 4'd1, 4'd0, 2'b00};
    tbl[1]  = '{4'd5, 4'd3, 4'd2, 4'd0, 2'b01};
    tbl[2]  = '{4'd4, 4'd4, 4'd0, 4'd0, 2'b00};
    tbl[3]  = '{4'd7, 4'd2, 4'd0, 4'd0, 2'b00};
    tbl[4]  = '{4'd1, 4'd6, 4'd0, 4'd1, 2'b00};
    tbl[5]  = '{4'd0, 4'd3, 4'd0, 4'd1, 2'b00};
    tbl[6]  = '{4'd2, 4'd6, 4'd0, 4'd2, 2'b10};
    tbl[7]  = '{4'd6, 4'd1, 4'd1, 4'd0, 2'b00};
    tbl[8]  = '{4'd1, 4'd2, 4'd1, 4'd1, 2'b00};
    tbl[9]  = '{4'd3, 4'd2, 4'd2, 4'd1, 2'b00};
    tbl[10] = '{4'd6, 4'd5, 4'd3, 4'd1, 2'b01};

    rst = 1'b1; start1 = 1'b1; start2 = 1'b1; dice_vld = 1'b0;
    dice1 = 4'd0; dice2 = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_roll", roll, 0);
    check("rst_hold", hold, 0);
    check("rst_finish", finish, 0);
    check("rst_winner", winner, 0);
    check("rst_score1", score1, 0);
    check("rst_score2", score2, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table; a tie with re-roll enabled feeds the next row's dice straight in.
    o1 = 4'd0; o2 = 4'd0;
    for (int i = 0; i < 11; i++) begin
      start_round(i % 3, bit'(i % 2));
      dice_phase(tbl[i].d1, tbl[i].d2, o1, o2, tbl[i].e1, tbl[i].e2, tbl[i].ew, i % 2);
      o1 = (tbl[i].ew != 0) ? 4'd0 : tbl[i].e1;
      o2 = (tbl[i].ew != 0) ? 4'd0 : tbl[i].e2;
    end
    m1 = o1; m2 = o2;

    // Presses during HOLD are ignored; two fresh presses are needed afterwards.
    if (pend) play_model(4'd2, 4'd1, 0, 1'b0, 0);
    press_and_roll(0, 1'b0);
    o1 = 4'(m1); o2 = 4'(m2);
    model_round(4'd2, 4'd1, e1, e2, ew);
    dice1 = 4'd2; dice2 = 4'd1; dice_vld = 1'b1;
    @(negedge clk); dice_vld = 1'b0;
    @(negedge clk);
    check("hp_hold", hold, 1);
    check("hp_score1", score1, e1);
    start1 = 1'b0; start2 = 1'b0;
    @(negedge clk); @(negedge clk);
    start1 = 1'b1; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    @(negedge clk); start2 = 1'b1;
    n = 0;
    while (hold === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hp_hold_exit", hold, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (roll) n++;
    end
    check("hp_stale_flags", n, 0);
    start1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (roll) n++;
    end
    start1 = 1'b1;
    check("hp_one_press", n, 0);
    start2 = 1'b0;
    @(negedge clk); check("hp_roll_lat1", roll, 0);
    @(negedge clk); check("hp_roll_lat2", roll, 1);
    start2 = 1'b1;
    @(negedge clk); check("hp_roll_single", roll, 0);
    o1 = 4'(m1); o2 = 4'(m2);
    model_round(4'd3, 4'd3, e1, e2, ew);
    dice_phase(4'd3, 4'd3, o1, o2, e1, e2, ew, 2);
    play_model(4'd4, 4'd1, 1, 1'b1, 0);

    // Reset in the middle of WIN: everything clears and no finish pulse follows.
    play_model(4'd5, 4'd3, 0, 1'b0, 0);
    press_and_roll(0, 1'b0);
    model_round(4'd5, 4'd3, e1, e2, ew);
    dice1 = 4'd5; dice2 = 4'd3; dice_vld = 1'b1;
    @(negedge clk); dice_vld = 1'b0;
    @(negedge clk);
    check("rw_score1", score1, e1);
    repeat (HOLD) @(negedge clk);
    check("rw_winner", winner, ew);
    check("rw_hold", hold, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rw_roll", roll, 0);
    check("rw_hold_clr", hold, 0);
    check("rw_finish", finish, 0);
    check("rw_winner_clr", winner, 0);
    check("rw_score1_clr", score1, 0);
    check("rw_score2_clr", score2, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (finish || hold) n++;
    end
    check("rw_no_finish", n, 0);
    m1 = 0; m2 = 0; pend = 1'b0;

    // Alternate wins up to 14:14, then push player 1 into saturation.
    for (int i = 0; i < 14; i++) begin
      play_model(4'd3, 4'd1, 0, 1'b0, 0);
      play_model(4'd1, 4'd3, 0, 1'b0, 0);
    end
    play_model(4'd6, 4'd2, 0, 1'b0, 0);
    play_model(4'd6, 4'd2, 0, 1'b0, 0);
    play_model(4'd2, 4'd6, 0, 1'b0, 0);
    play_model(4'd5, 4'd4, 0, 1'b0, 0);

    // Random rounds against the rule model.
    for (int i = 0; i < 40; i++) begin
      play_model(rand_die(), rand_die(), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 3000000, result-display hold per round in clk cycles (3 s).
REQ-002 Parameter WIN_CYCLES, default 5000000, winner-display hold in clk cycles (5 s).
REQ-003 Parameter WIN_MARGIN, default 2, score lead that ends a game.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start1  input  1  player-1 button, synchronous level; a falling edge is one press.
REQ-007 start2  input  1  player-2 button, synchronous level; a falling edge is one press.
REQ-008 roll  output  1  one-cycle pulse requesting both dice generators to roll.
REQ-009 dice_vld  input  1  one-cycle pulse: dice1/dice2 are valid.
REQ-010 dice1  input  4  player-1 die value, 1..6.
REQ-011 dice2  input  4  player-2 die value, 1..6.
REQ-012 score1  output  4  player-1 round wins.
REQ-013 score2  output  4  player-2 round wins.
REQ-014 winner  output  2  00 none, 01 player 1, 10 player 2; 11 never driven.
REQ-015 hold  output  1  high while in HOLD or WIN (display freeze).
REQ-016 finish  output  1  one-cycle pulse on the last cycle of WIN.

Function
REQ-017 FSM states: WAIT, ROLL, DICE, SCORE, HOLD, WIN; next-state and outputs registered.
REQ-018 WAIT: press flags p1/p2 set on falling edges of start1/start2; both edges in the same cycle set both flags.
REQ-019 WAIT -> ROLL in the cycle after p1 and p2 are both set; flags clear on the transition.
REQ-020 Presses outside WAIT are ignored and do not set flags; edge-detect history registers update every cycle.
REQ-021 ROLL: roll=1 for exactly one cycle, then DICE.
REQ-022 DICE: on dice_vld, latch dice1/dice2 and go to SCORE; waits indefinitely without dice_vld.
REQ-023 Latched die value 0 or >6 is a fault: no score change, go directly to WAIT.
REQ-024 SCORE (one cycle): larger die increments its score, saturating at 15; equal dice change nothing.
REQ-025 SCORE -> HOLD; HOLD counts HOLD_CYCLES cycles (counter from 0 to HOLD_CYCLES-1), hold=1.
REQ-026 End of HOLD: if |score1-score2| >= WIN_MARGIN -> WIN with winner set to leader, else -> WAIT.
REQ-027 WIN counts WIN_CYCLES cycles, hold=1; finish=1 on final cycle; next cycle score1, score2, winner cleared, state WAIT.
REQ-028 Difference computed unsigned as larger minus smaller, 4-bit, no wrap.
REQ-029 Latency: second press edge to roll pulse = 2 cycles; dice_vld to score update = 2 cycles.

Reset
REQ-030 rst=1 on a clock edge: state WAIT, roll=0, score1=score2=0, winner=00, hold=0, finish=0, counter=0, p1=p2=0, edge history=0.
REQ-031 rst mid-HOLD or mid-WIN aborts the count; no finish pulse is emitted.

Configuration
REQ-032 Macro ROUND_TIE_REROLL_EN defined: tie in SCORE goes directly to ROLL (no HOLD, no new presses).
REQ-033 Macro ROUND_TIE_REROLL_EN undefined: tie goes through HOLD then WAIT like any other round.

Structure
REQ-034 Shared package round_pkg holds the state enum, winner encodings (WIN_NONE, WIN_P1, WIN_P2) and default timing constants.
REQ-035 One sub-module, edge_fall_det (one per button), produces the falling-edge pulse; counter and FSM stay in round_ctrl.

Verification (HOLD_CYCLES=10, WIN_CYCLES=20 for simulation)
REQ-036 start1 and start2 fall in same cycle -> roll pulse 2 cycles later, exactly one pulse.
REQ-037 dice 5/3 twice -> score1=1 then 2, WIN entered, winner=01, finish pulse after 20 cycles, scores 0 next cycle.
REQ-038 dice 4/4 without macro -> scores unchanged, hold high 10 cycles, back to WAIT; with macro -> roll pulse next cycle after SCORE.
REQ-039 presses during HOLD -> ignored; FSM still requires two fresh presses in WAIT.
REQ-040 dice1=7 -> no score change, WAIT next cycle, hold never asserted.
REQ-041 rst asserted at WIN cycle 5 -> all outputs at reset values, no finish pulse.
